// File: rtl/alu16_checker.sv
// alu16_checker: shadow reference for a 16-bit ALU. Recomputes each accepted
// operation, compares it against the ALU's registered outputs one cycle later,
// and keeps pass/fail statistics plus a capture of the first failure.
module alu16_checker #(
    parameter int unsigned CHECK_V     = 1,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] dut_y,
    input  logic        dut_z,
    input  logic        dut_c,
    input  logic        dut_v,
    output logic        mismatch,
    output logic        err_sticky,
    output logic [31:0] txn_count,
    output logic [15:0] err_count,
    output logic [3:0]  first_err_op,
    output logic [31:0] first_err_idx,
    output logic [1:0]  state
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;
    localparam int unsigned TW  = 32;
    localparam int unsigned EW  = 16;

    localparam bit CHK_V = (CHECK_V != 0);
    localparam bit STOP  = (STOP_ON_ERR != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q;

    logic [DW:0]     exp_tmp_c;
    logic [DW-1:0]   exp_y_c;
    logic            exp_z_c;
    logic            exp_c_c;
    logic            exp_v_c;

    logic            pend_valid;
    logic [OPW-1:0]  pend_op;
    logic [DW-1:0]   exp_y_q;
    logic            exp_z_q;
    logic            exp_c_q;
    logic            exp_v_q;

    logic            accept_c;
    logic            diff_c;
    logic            fail_c;
    logic            halt_c;

    assign state = state_q;

    // Reference result for the operands currently presented to the ALU
    always_comb begin
        exp_tmp_c = '0;
        case (op)
            4'd1:    exp_tmp_c = {1'b0, a} - {1'b0, b};
            4'd2:    exp_tmp_c = {1'b0, a & b};
            4'd3:    exp_tmp_c = {1'b0, a | b};
            4'd4:    exp_tmp_c = {1'b0, a ^ b};
            default: exp_tmp_c = {1'b0, a} + {1'b0, b};
        endcase
        exp_y_c = exp_tmp_c[DW-1:0];
        exp_c_c = exp_tmp_c[DW];
        exp_z_c = (exp_y_c == '0);
        exp_v_c = 1'b0;
        if (op == 4'd0) begin
            exp_v_c = (a[DW-1] == b[DW-1]) && (exp_y_c[DW-1] != a[DW-1]);
        end else if (op == 4'd1) begin
            exp_v_c = (a[DW-1] != b[DW-1]) && (exp_y_c[DW-1] != a[DW-1]);
        end
    end

    assign accept_c = (state_q == ST_RUN) && in_valid;
    assign diff_c   = (dut_y != exp_y_q) || (dut_z != exp_z_q) || (dut_c != exp_c_q)
                   || (CHK_V && (dut_v != exp_v_q));
    assign fail_c   = pend_valid && diff_c;
    assign halt_c   = STOP && fail_c && (state_q == ST_RUN);

    // Pending-compare stage; a transaction accepted while halting is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_op    <= '0;
            exp_y_q    <= '0;
            exp_z_q    <= 1'b0;
            exp_c_q    <= 1'b0;
            exp_v_q    <= 1'b0;
        end else begin
            pend_valid <= accept_c && !halt_c;
            if (accept_c) begin
                pend_op <= op;
                exp_y_q <= exp_y_c;
                exp_z_q <= exp_z_c;
                exp_c_q <= exp_c_c;
                exp_v_q <= exp_v_c;
            end
        end
    end

    // Run-control state machine; HALT only leaves on clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (en) state_q <= ST_RUN;
                ST_RUN: begin
                    if (halt_c) begin
                        state_q <= ST_HALT;
                    end else if (!en) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HALT: if (clr) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Compare result, counters and first-failure capture; clr wins over updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch      <= 1'b0;
            err_sticky    <= 1'b0;
            txn_count     <= '0;
            err_count     <= '0;
            first_err_op  <= '0;
            first_err_idx <= '0;
        end else begin
            mismatch <= fail_c;
            if (clr) begin
                err_sticky    <= 1'b0;
                txn_count     <= '0;
                err_count     <= '0;
                first_err_op  <= '0;
                first_err_idx <= '0;
            end else begin
                if (pend_valid) begin
                    txn_count <= txn_count + TW'(1);
                end
                if (fail_c) begin
                    err_sticky <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + EW'(1);
                    end
                    if (!err_sticky) begin
                        first_err_op  <= pend_op;
                        first_err_idx <= txn_count;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu16_checker.sv
// Bench for alu16_checker: drives ALU stimulus plus the ALU's registered
// outputs, predicts each mismatch pulse into a scoreboard queue and checks it
// from an independent monitor process.
module tb_alu16_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        en_s = 1'b0;
    logic        clr_s = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] dut_y = '0;
    logic        dut_z = 1'b0;
    logic        dut_c = 1'b0;
    logic        dut_v = 1'b0;

    logic        mismatch, err_sticky;
    logic [31:0] txn_count, first_err_idx;
    logic [15:0] err_count;
    logic [3:0]  first_err_op;
    logic [1:0]  state;

    logic        n_mismatch, n_err_sticky;
    logic [31:0] n_txn_count, n_first_err_idx;
    logic [15:0] n_err_count;
    logic [3:0]  n_first_err_op;
    logic [1:0]  n_state;

    logic        s_mismatch, s_err_sticky;
    logic [31:0] s_txn_count, s_first_err_idx;
    logic [15:0] s_err_count;
    logic [3:0]  s_first_err_op;
    logic [1:0]  s_state;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    // ALU outputs staged for presentation one cycle after the operands
    logic [15:0] st_y = '0;
    logic        st_z = 1'b0;
    logic        st_c = 1'b0;
    logic        st_v = 1'b0;

    typedef struct {
        int unsigned due;
        bit          mm;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        z;
        logic        c;
        logic        v;
        logic        mm;
    } vec_t;

    // Hand-computed directed vectors; the last two present a wrong c and a wrong z
    vec_t vecs [11] = '{
        '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0},
        '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd3,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0},
        '{4'd4,  16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd9,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
        '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'd0,  16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0},
        '{4'd15, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0},
        '{4'd1,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
        '{4'd2,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1},
        '{4'd3,  16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1}
    };

    alu16_checker u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
        .op(op), .a(a), .b(b), .dut_y(dut_y), .dut_z(dut_z), .dut_c(dut_c),
        .dut_v(dut_v), .mismatch(mismatch), .err_sticky(err_sticky),
        .txn_count(txn_count), .err_count(err_count),
        .first_err_op(first_err_op), .first_err_idx(first_err_idx), .state(state)
    );

    alu16_checker #(.CHECK_V(0)) u_nov (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
        .op(op), .a(a), .b(b), .dut_y(dut_y), .dut_z(dut_z), .dut_c(dut_c),
        .dut_v(dut_v), .mismatch(n_mismatch), .err_sticky(n_err_sticky),
        .txn_count(n_txn_count), .err_count(n_err_count),
        .first_err_op(n_first_err_op), .first_err_idx(n_first_err_idx), .state(n_state)
    );

    alu16_checker #(.STOP_ON_ERR(1)) u_stop (
        .clk(clk), .rst_n(rst_n), .en(en_s), .clr(clr_s), .in_valid(in_valid),
        .op(op), .a(a), .b(b), .dut_y(dut_y), .dut_z(dut_z), .dut_c(dut_c),
        .dut_v(dut_v), .mismatch(s_mismatch), .err_sticky(s_err_sticky),
        .txn_count(s_txn_count), .err_count(s_err_count),
        .first_err_op(s_first_err_op), .first_err_idx(s_first_err_idx), .state(s_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: present last cycle's ALU result, apply new operands
    task automatic step(input logic iv, input logic [3:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, input logic [15:0] ry, input logic rz,
                        input logic rc, input logic rv, input bit push, input bit mm);
        sb_t e;
        @(negedge clk);
        dut_y    = st_y;
        dut_z    = st_z;
        dut_c    = st_c;
        dut_v    = st_v;
        in_valid = iv;
        op       = o;
        a        = aa;
        b        = bb;
        st_y     = ry;
        st_z     = rz;
        st_c     = rc;
        st_v     = rv;
        if (push) begin
            e.due = cyc + 2;
            e.mm  = mm;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        idle(1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    // Independent reference for the random stream, written in integer arithmetic
    function automatic void ref_alu(input logic [3:0] o, input logic [15:0] x,
                                    input logic [15:0] w, output logic [15:0] r,
                                    output logic rz, output logic rc, output logic rv);
        int ux, uw, sx, sw, full, sres;
        ux = int'({16'd0, x});
        uw = int'({16'd0, w});
        sx = int'($signed(x));
        sw = int'($signed(w));
        rc = 1'b0;
        rv = 1'b0;
        case (o)
            4'd1: begin
                full = ux - uw;
                rc   = (ux < uw);
                sres = sx - sw;
                rv   = (sres > 32767) || (sres < -32768);
            end
            4'd2: full = int'({16'd0, x & w});
            4'd3: full = int'({16'd0, x | w});
            4'd4: full = int'({16'd0, x ^ w});
            default: begin
                full = ux + uw;
                rc   = (full > 65535);
                sres = sx + sw;
                rv   = (o == 4'd0) && ((sres > 32767) || (sres < -32768));
            end
        endcase
        r  = full[15:0];
        rz = (r == 16'd0);
    endfunction

    // Scoreboard monitor for the main instance's mismatch pulse
    always @(negedge clk) begin
        sb_t e;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (mismatch !== e.mm) begin
                errors++;
                $display("FAIL mismatch_pulse cyc=%0d actual=%b required=%b", cyc, mismatch, e.mm);
            end
        end else if (rst_n && mismatch !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mismatch cyc=%0d actual=%b required=0", cyc, mismatch);
        end
    end

    initial begin
        logic [3:0]  ro;
        logic [15:0] ra, rb, ry;
        logic        rz, rc, rv;

        // Reset values, and IDLE on the first cycle after release even with en=1
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_idle", 32'(state), 32'd0);
        @(negedge clk);
        chk("idle_to_run", 32'(state), 32'd1);

        // Add with carry out, correct ALU
        step(1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("carry_txn", txn_count, 32'd1);
        chk("carry_err", 32'(err_count), 32'd0);

        // Signed overflow with dut_v stuck at 0
        pulse_clr();
        step(1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        chk("ovf_err", 32'(err_count), 32'd1);
        chk("ovf_sticky", 32'(err_sticky), 32'd1);
        chk("ovf_first_op", 32'(first_err_op), 32'd0);
        chk("ovf_first_idx", first_err_idx, 32'd0);
        chk("ovf_txn", txn_count, 32'd1);
        chk("nov_err", 32'(n_err_count), 32'd0);
        chk("nov_sticky", 32'(n_err_sticky), 32'd0);
        chk("nov_txn", n_txn_count, 32'd1);

        // Directed vectors back-to-back, including subtract borrow
        pulse_clr();
        chk("clr_err", 32'(err_count), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].z,
                 vecs[i].c, vecs[i].v, 1'b1, vecs[i].mm);
        end
        idle(3);
        chk("vec_txn", txn_count, 32'd11);
        chk("vec_err", 32'(err_count), 32'd2);
        chk("vec_first_op", 32'(first_err_op), 32'd2);
        chk("vec_first_idx", first_err_idx, 32'd9);

        // Random back-to-back stream, then three forced bad results
        pulse_clr();
        for (int i = 0; i < 1000; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            ref_alu(ro, ra, rb, ry, rz, rc, rv);
            step(1'b1, ro, ra, rb, ry, rz, rc, rv, 1'b1, 1'b0);
        end
        idle(3);
        chk("stream_txn", txn_count, 32'd1000);
        chk("stream_err", 32'(err_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd0, 16'd0, 16'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle(3);
        chk("force_err", 32'(err_count), 32'd3);
        chk("force_sticky", 32'(err_sticky), 32'd1);
        chk("force_txn", txn_count, 32'd1003);
        chk("force_first_idx", first_err_idx, 32'd1000);

        // Reset between accept and compare drops the pending compare
        step(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dut_y    = st_y;
        st_y     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_txn", txn_count, 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_sticky", 32'(err_sticky), 32'd0);
        chk("midrst_first_idx", first_err_idx, 32'd0);
        chk("midrst_mismatch", 32'(mismatch), 32'd0);
        idle(4);
        chk("midrst_run", 32'(state), 32'd1);

        // Pending compare finishes after en drops; clr in the same cycle wins
        step(1'b1, 4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd4, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd2, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        clr = 1'b1;
        en  = 1'b0;
        idle(1);
        clr = 1'b0;
        chk("clrmm_txn", txn_count, 32'd0);
        chk("clrmm_err", 32'(err_count), 32'd0);
        chk("clrmm_sticky", 32'(err_sticky), 32'd0);
        chk("clrmm_first_op", 32'(first_err_op), 32'd0);
        chk("clrmm_state", 32'(state), 32'd0);

        // Stop-on-error instance: fail on txn 5, the next txn is discarded
        en_s = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0, 16'(i), 16'd1, 16'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'd3, 16'h0F00, 16'h00F0, 16'h0FF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(2);
        chk("stop_state", 32'(s_state), 32'd2);
        chk("stop_txn", s_txn_count, 32'd6);
        chk("stop_err", 32'(s_err_count), 32'd1);
        chk("stop_first_op", 32'(s_first_err_op), 32'd3);
        chk("stop_first_idx", s_first_err_idx, 32'd5);
        chk("idle_ignores_valid", txn_count, 32'd0);
        chk("idle_state_held", 32'(state), 32'd0);
        idle(1);
        clr_s = 1'b1;
        en_s  = 1'b0;
        idle(1);
        clr_s = 1'b0;
        chk("stop_clr_state", 32'(s_state), 32'd0);
        chk("stop_clr_txn", s_txn_count, 32'd0);
        chk("stop_clr_err", 32'(s_err_count), 32'd0);
        chk("stop_clr_sticky", 32'(s_err_sticky), 32'd0);
        chk("stop_clr_first_idx", s_first_err_idx, 32'd0);

        idle(3);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu16_checker.md
ALU16_CHECKER -- requirements
Module: alu16_checker

Interface
REQ-001 SHALL have parameter CHECK_V, default 1, meaning that 1 compares the v flag and 0 masks it.
REQ-002 SHALL have parameter STOP_ON_ERR, default 0, meaning that 1 moves to HALT on the first mismatch.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: run enable.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of counters, sticky error and capture registers.
REQ-007 SHALL have port in_valid, input, 1 bit: op/a/b are being applied to the ALU this cycle.
REQ-008 SHALL have port op, input, 4 bits: ALU opcode as driven to the ALU.
REQ-009 SHALL have ports a and b, input, 16 bits each: operands as driven to the ALU.
REQ-010 SHALL have ports dut_y (16 bits) and dut_z, dut_c, dut_v (1 bit each), inputs: the ALU's registered outputs.
REQ-011 SHALL have port mismatch, output, 1 bit: one-cycle pulse per failed compare.
REQ-012 SHALL have port err_sticky, output, 1 bit: set on any mismatch.
REQ-013 SHALL have port txn_count, output, 32 bits: number of compares performed.
REQ-014 SHALL have port err_count, output, 16 bits: number of mismatches, saturating.
REQ-015 SHALL have ports first_err_op (4 bits) and first_err_idx (32 bits), outputs: opcode and txn index of the first mismatch.
REQ-016 SHALL have port state, output, 2 bits: 0=IDLE, 1=RUN, 2=HALT.

Function
REQ-017 SHALL accept a transaction only when state==RUN and in_valid=1, registering op, a, b and the expected result on that edge.
REQ-018 SHALL compute expected tmp[16:0] with zero-extended operands: op 0 is a+b, 1 is a-b, 2 is a&b, 3 is a|b, 4 is a^b, and 5..15 is a+b.
REQ-019 SHALL set expected y=tmp[15:0], c=tmp[16] (borrow for sub, 0 for logic ops) and z=(tmp[15:0]==0).
REQ-020 SHALL set expected v for op 0 as (a[15]==b[15]) && (y[15]!=a[15]), for op 1 as (a[15]!=b[15]) && (y[15]!=a[15]), and 0 otherwise, where y is the expected y of the same transaction.
REQ-021 SHALL, for a transaction accepted at edge N, compare dut_* against the expected value during cycle N+1, with the dut_* values being those the ALU registered at edge N.
REQ-022 SHALL register the compare result at edge N+1, so mismatch is high for exactly cycle N+2.
REQ-023 SHALL raise a mismatch on any difference in y, z or c, or in v when CHECK_V=1.
REQ-024 SHALL increment txn_count by 1 on every compare, wrapping 0xFFFFFFFF to 0.
REQ-025 SHALL increment err_count on every mismatch, holding at 0xFFFF.
REQ-026 SHALL capture first_err_op and first_err_idx (the txn_count value before its increment) only while err_sticky=0.
REQ-027 SHALL move IDLE to RUN on en=1.
REQ-028 SHALL move RUN to IDLE on en=0, while still completing any compare already pending.
REQ-029 SHALL move RUN to HALT on mismatch when STOP_ON_ERR=1.
REQ-030 SHALL move HALT to IDLE on clr=1, and SHALL ignore en while in HALT.
REQ-031 SHALL sustain back-to-back transactions, one per cycle, with the pipeline fully overlapped and no bubbles.
REQ-032 SHALL, on clr=1 together with a mismatch in the same cycle, give clr priority: counters, err_sticky and capture go to 0, and the mismatch pulse still fires.
REQ-033 SHALL ignore in_valid=1 outside RUN: no accept, no compare, no count.
REQ-034 SHALL, on entry to HALT, discard any transaction accepted in the mismatching cycle; it is not compared.

Reset
REQ-035 SHALL, while rst_n=0 and asynchronously, force state=IDLE, mismatch=0, err_sticky=0, txn_count=0, err_count=0, first_err_op=0, first_err_idx=0, and the pending-compare valid bit to 0.
REQ-036 SHALL, when reset is asserted mid-operation, drop any pending compare, and SHALL NOT raise mismatch for it after release.
REQ-037 SHALL leave the first cycle after rst_n deassertion in IDLE, regardless of en.

Verification
REQ-038 SHALL verify add carry: a=0xFFFF, b=0x0001, op=0, with the ALU correct -> no mismatch, expected y=0x0000, z=1, c=1, txn_count=1.
REQ-039 SHALL verify signed overflow: a=0x7FFF, b=0x0001, op=0, with dut_v forced to 0 -> mismatch at N+2, err_count=1, first_err_op=0, first_err_idx=0; with CHECK_V=0 -> no mismatch.
REQ-040 SHALL verify subtract borrow: a=0x0000, b=0x0001, op=1 -> expected y=0xFFFF, c=1, v=0, and a correct ALU gives no mismatch.
REQ-041 SHALL verify streaming: 1000 random back-to-back ops 0..15 -> txn_count=1000 and err_count=0; forcing dut_y to 0x1234 for 3 cycles -> err_count=3 and err_sticky=1.
REQ-042 SHALL verify STOP_ON_ERR=1: a mismatch on txn 5 -> state=HALT, txn_count=6, further in_valid ignored; clr -> IDLE with all counters at 0.
REQ-043 SHALL verify reset mid-operation: rst_n pulsed low for 1 cycle between accept and compare -> no mismatch, all outputs 0, state=IDLE.
